// File: rtl/glip_traffic_gen_check_if.sv
// glip_traffic_gen_check_if: GLIP FIFO stream pair between host side and traffic generator/checker
//  in_data/in_valid/in_ready    host->logic stream (slave consumes)
//  out_data/out_valid/out_ready logic->host stream (slave produces)
//  master: host/testbench view, slave: glip_traffic_gen_check view
interface glip_traffic_gen_check_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/glip_traffic_gen_check.sv
// glip_traffic_gen_check: command-driven loopback / pattern generator / pattern checker on GLIP FIFOs
//  clk        GLIP fifo clock
//  rst_n      asynchronous reset, active-low
//  i_sync_rst synchronous clear, same effect as rst_n
//  bus        glip_traffic_gen_check_if.slave (in_* consumed, out_* registered output)
//  o_busy     state != IDLE
//  o_err      sticky CHECK mismatch flag
//  Header word = {op[WIDTH-1:WIDTH-2], len[WIDTH-3:0]}; op 00 LOOP, 01 GEN, 10 CHECK, 11 SEED.
//  GLIP_TGC_LFSR_EN: pattern advances as a 16-bit Fibonacci LFSR instead of a counter
//  (seed 0 replaced by 1 when loaded; WIDTH must be 16).
module glip_traffic_gen_check #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_sync_rst,
  glip_traffic_gen_check_if.slave bus,
  output logic                 o_busy,
  output logic                 o_err
);
  typedef enum logic [2:0] {S_IDLE, S_SEED, S_LOOP, S_GEN, S_CHECK, S_STATUS} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_seed, r_pat, r_err_cnt, r_out_data, w_pat_next, w_pat_init;
  logic [WIDTH-3:0] r_remain, w_len;
  logic [1:0]       w_op;
  logic             r_out_valid, r_err, w_free, w_in_ready, w_in_xfer, w_last, w_step, w_load, w_mismatch;
`ifdef GLIP_TGC_LFSR_EN
  if (WIDTH != 16) begin : g_width_chk
    $error("GLIP_TGC_LFSR_EN requires WIDTH == 16");
  end
  assign w_pat_next = {r_pat[WIDTH-2:0], r_pat[15] ^ r_pat[13] ^ r_pat[12] ^ r_pat[10]};
  // an all-zero LFSR state would lock up
  assign w_pat_init = (r_seed == '0) ? WIDTH'(1) : r_seed;
`else
  assign w_pat_next = r_pat + WIDTH'(1);
  assign w_pat_init = r_seed;
`endif
  assign w_op       = bus.in_data[WIDTH-1:WIDTH-2];
  assign w_len      = bus.in_data[WIDTH-3:0];
  assign w_free     = !r_out_valid || bus.out_ready;
  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_last     = r_remain == (WIDTH-2)'(1);
  assign w_mismatch = bus.in_data != r_pat;
  // one payload word consumed or produced in a counted state
  assign w_step     = ((r_state == S_LOOP || r_state == S_CHECK) && w_in_xfer) || (r_state == S_GEN && w_free);
  assign w_load     = (r_state == S_LOOP && w_in_xfer) || ((r_state == S_GEN || r_state == S_STATUS) && w_free);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign o_err         = r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= i_sync_rst ? S_IDLE : w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_in_xfer) w_state_nxt = (w_op == 2'b11) ? S_SEED :
                                             (w_len == '0)  ? ((w_op == 2'b10) ? S_STATUS : S_IDLE) :
                                             (w_op == 2'b00) ? S_LOOP :
                                             (w_op == 2'b01) ? S_GEN : S_CHECK;
      S_SEED:   if (w_in_xfer) w_state_nxt = S_IDLE;
      S_LOOP,
      S_GEN:    if (w_step && w_last) w_state_nxt = S_IDLE;
      S_CHECK:  if (w_step && w_last) w_state_nxt = S_STATUS;
      S_STATUS: if (w_free) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    w_in_ready = rst_n && (r_state == S_IDLE || r_state == S_SEED || r_state == S_CHECK ||
                           (r_state == S_LOOP && w_free));
    o_busy     = r_state != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_seed      <= '0;
      r_pat       <= '0;
      r_remain    <= '0;
      r_err_cnt   <= '0;
      r_err       <= 1'b0;
    end else if (i_sync_rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_seed      <= '0;
      r_pat       <= '0;
      r_remain    <= '0;
      r_err_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= (r_state == S_LOOP) ? bus.in_data : (r_state == S_GEN) ? r_pat : r_err_cnt;
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) r_out_valid <= 1'b0;
      if (r_state == S_IDLE && w_in_xfer) r_remain <= w_len;
      else if (w_step) r_remain <= r_remain - (WIDTH-2)'(1);
      if (r_state == S_SEED && w_in_xfer) r_seed <= bus.in_data;
      // GEN and CHECK headers restart the pattern from the seed
      if (r_state == S_IDLE && w_in_xfer && (w_op[1] ^ w_op[0])) r_pat <= w_pat_init;
      else if (w_step && r_state != S_LOOP) r_pat <= w_pat_next;
      if (r_state == S_IDLE && w_in_xfer && w_op == 2'b10) r_err_cnt <= '0;
      else if (r_state == S_CHECK && w_in_xfer && w_mismatch && r_err_cnt != '1) r_err_cnt <= r_err_cnt + WIDTH'(1);
      if (r_state == S_CHECK && w_in_xfer && w_mismatch) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_glip_traffic_gen_check.sv
// tb_glip_traffic_gen_check: directed and randomized command streams against a queue-based reference model
module tb_glip_traffic_gen_check;
  logic clk = 1'b0, rst_n = 1'b0, sync_rst = 1'b0, busy, err;
  glip_traffic_gen_check_if #(.WIDTH(16)) bus();
  glip_traffic_gen_check #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .i_sync_rst(sync_rst), .bus(bus), .o_busy(busy), .o_err(err));
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0, rdy_mode = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_seed = 16'h0000, held = 16'h0000;
  logic m_err = 1'b0, stalled = 1'b0;
`ifdef GLIP_TGC_LFSR_EN
  localparam logic [15:0] START0 = 16'h0001;
`else
  localparam logic [15:0] START0 = 16'h0000;
`endif
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask
  function automatic logic [15:0] m_next(input logic [15:0] p);
`ifdef GLIP_TGC_LFSR_EN
    return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
`else
    return p + 16'd1;
`endif
  endfunction
  function automatic logic [15:0] m_start(input logic [15:0] s);
`ifdef GLIP_TGC_LFSR_EN
    return (s == 16'h0000) ? 16'h0001 : s;
`else
    return s;
`endif
  endfunction
  // output-side scoreboard: every accepted word must be the next expected one, stalls must hold
  always @(negedge clk) begin
    #2;
    if (!rst_n || sync_rst) stalled = 1'b0;
    else begin
      if (stalled) begin
        chk("hold_valid", 16'(bus.out_valid), 16'h1);
        chk("hold_data", bus.out_data, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_out: got %h, want no word", bus.out_data);
        end else chk("out_data", bus.out_data, exp_q.pop_front());
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
    end
  end
  task automatic step();
    @(negedge clk);
    if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) bus.out_ready = !bus.out_ready;
  endtask
  task automatic send(input logic [15:0] w);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int n = 0; n < 300 && !acc; n++) begin
      #1 acc = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", 16'(acc), 16'h1);
  endtask
  task automatic drain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) step();
    chk("drain_empty", 16'(exp_q.size()), 16'h0);
    step();
    step();
    chk("busy_idle", 16'(busy), 16'h0);
    chk("err_flag", 16'(err), 16'(m_err));
  endtask
  task automatic cmd_seed(input logic [15:0] s);
    send({2'b11, 14'($urandom)});
    send(s);
    m_seed = s;
  endtask
  task automatic cmd_loop(input int n);
    logic [15:0] w;
    send({2'b00, 14'(n)});
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      send(w);
    end
  endtask
  task automatic cmd_gen(input int n);
    logic [15:0] p;
    p = m_start(m_seed);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = m_next(p);
    end
    send({2'b01, 14'(n)});
  endtask
  task automatic cmd_check(input int n, input int bad_pct);
    logic [15:0] p, w, cnt;
    p = m_start(m_seed);
    cnt = 16'h0000;
    send({2'b10, 14'(n)});
    for (int i = 0; i < n; i++) begin
      w = ($urandom_range(0, 99) < bad_pct) ? p ^ 16'($urandom_range(1, 65535)) : p;
      if (w != p && cnt != 16'hFFFF) cnt = cnt + 16'd1;
      send(w);
      p = m_next(p);
    end
    exp_q.push_back(cnt);
    if (cnt != 16'h0000) m_err = 1'b1;
  endtask
  task automatic mid_gen_stop();
    for (int n = 0; n < 100 && exp_q.size() > 6; n++) step();
    bus.out_ready = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c;
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0000;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 16'(bus.in_ready), 16'h0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_out_data", bus.out_data, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
`ifndef GLIP_TGC_LFSR_EN
    send(16'hC000);
    send(16'h0010);
    m_seed = 16'h0010;
    exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    send(16'h4004);
    c = 0;
    while (exp_q.size() != 0 && c < 20) begin
      step();
      c++;
    end
    chk("gen_back_to_back", 16'(c), 16'd5);
    drain();
`endif
    rdy_mode = 2;
    exp_q = '{16'hA5A5, 16'h1234, 16'hFFFF};
    send(16'h0003);
    send(16'hA5A5);
    send(16'h1234);
    send(16'hFFFF);
    drain();
    rdy_mode = 0;
    bus.out_ready = 1'b1;
`ifndef GLIP_TGC_LFSR_EN
    send(16'hC000);
    send(16'h0000);
    m_seed = 16'h0000;
    send(16'h8004);
    send(16'h0000);
    send(16'h0001);
    send(16'h0005);
    send(16'h0003);
    exp_q.push_back(16'h0001);
    m_err = 1'b1;
    drain();
    send(16'hC000);
    send(16'hFFFE);
    m_seed = 16'hFFFE;
    exp_q = '{16'hFFFE, 16'hFFFF, 16'h0000};
    send(16'h4003);
    drain();
    exp_q.push_back(16'h0000);
    send(16'h8000);
    drain();
`else
    send(16'hC000);
    send(16'h0000);
    m_seed = 16'h0000;
    exp_q = '{16'h0001, 16'h0002, 16'h0004};
    send(16'h4003);
    drain();
    send(16'h8003);
    send(16'h0001);
    send(16'h0002);
    send(16'h0004);
    exp_q.push_back(16'h0000);
    drain();
`endif
    cmd_seed(16'h1234);
    cmd_gen(8);
    mid_gen_stop();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("arst_busy", 16'(busy), 16'h0);
    chk("arst_in_ready", 16'(bus.in_ready), 16'h0);
    exp_q.delete();
    m_seed = 16'h0000;
    m_err = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(START0);
    send(16'h4001);
    drain();
    cmd_seed(16'h2222);
    cmd_gen(8);
    mid_gen_stop();
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    #1;
    chk("srst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("srst_out_data", bus.out_data, 16'h0000);
    chk("srst_busy", 16'(busy), 16'h0);
    exp_q.delete();
    m_seed = 16'h0000;
    m_err = 1'b0;
    step();
    bus.out_ready = 1'b1;
    exp_q.push_back(START0);
    send(16'h4001);
    drain();
    rdy_mode = 1;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: cmd_loop($urandom_range(0, 6));
        1: cmd_gen($urandom_range(0, 8));
        2: cmd_check($urandom_range(0, 6), 25);
        default: cmd_seed(($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom));
      endcase
      if ($urandom_range(0, 3) == 0) step();
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
